// File: rtl/lc4_insn_encoder.sv
// ---------------------------------------------------------------------------
// lc4_insn_encoder
//   Packs LC4 instruction fields into 20-bit instruction words. Each legal
//   request becomes one word one cycle after acceptance. Control transfers
//   (JSR, RTI) are followed by CTRL_PAD all-zero pad NOP words. Illegal
//   opcodes are accepted and dropped, with a one-cycle error pulse.
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   The producer keeps valid and its payload stable until that edge.
//   Ready never depends on valid from the same side.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   in_valid / in_ready     : request handshake
//   in_op, in_rd, in_rs,
//   in_rt, in_imm           : instruction fields
//   out_valid / out_ready   : output word handshake
//   out_insn                : encoded word
//   out_is_pad              : out_insn is an inserted pad NOP
//   err_illegal             : illegal opcode was accepted and dropped
//   insn_count              : non-pad words delivered, wraps at 16 bits
//   state_dbg               : FSM state (0 empty, 1 insn, 2 pad)
// ---------------------------------------------------------------------------
module lc4_insn_encoder #(
    parameter int CTRL_PAD = 2   // 0..7 pad words after JSR/RTI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [14:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_insn,
    output logic        out_is_pad,
    output logic        err_illegal,
    output logic [15:0] insn_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_INSN  = 2'd1,
        S_PAD   = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  pad_left, left_nx;
    logic [19:0] insn_nx;
    logic        pad_nx, valid_nx, err_nx;
    logic [15:0] count_nx;

    logic [19:0] enc;
    logic        illegal, is_ctrl;
    logic        accept, deliver;

    assign out_valid = (state != S_EMPTY);
    assign state_dbg = state;
    assign in_ready  = (pad_left == 3'd0) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    // Field packing by opcode format. Fields a format does not use are
    // never routed into the word.
    always_comb begin
        enc     = 20'h00000;
        illegal = 1'b0;
        is_ctrl = 1'b0;
        case (in_op)
            5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110,
            5'b01111, 5'b10010, 5'b10100, 5'b10101:
                enc = {in_op, in_rd, in_rs, in_rt};
            5'b00111, 5'b01001, 5'b10110:
                enc = {in_op, in_rd, in_rs, in_imm[4:0]};
            5'b10000, 5'b10011, 5'b11001:
                enc = {in_op, 5'b00000, in_rs, 5'b00000};
            5'b01011, 5'b10111, 5'b11000:
                enc = {in_op, in_rd, in_imm[9:0]};
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100:
                enc = {in_op, in_imm};
            5'b01000: begin
                enc     = {in_op, in_imm};
                is_ctrl = 1'b1;
            end
            5'b01010: begin
                enc     = {in_op, 15'h0000};
                is_ctrl = 1'b1;
            end
            // 10001 has no defined operands: emitted as a bare opcode.
            5'b10001:
                enc = {in_op, 15'h0000};
            default:
                illegal = 1'b1;
        endcase
    end

    // Next-state and output-register logic.
    always_comb begin
        valid_nx = out_valid;
        insn_nx  = out_insn;
        pad_nx   = out_is_pad;
        left_nx  = pad_left;
        err_nx   = 1'b0;
        count_nx = insn_count;
        state_nx = state;

        if (deliver && !out_is_pad) begin
            count_nx = insn_count + 16'd1;
        end

        if (accept) begin
            if (illegal) begin
                // Any held word is being delivered this cycle, so the
                // output simply goes empty.
                err_nx   = 1'b1;
                valid_nx = 1'b0;
                pad_nx   = 1'b0;
            end else begin
                valid_nx = 1'b1;
                insn_nx  = enc;
                pad_nx   = 1'b0;
                left_nx  = is_ctrl ? 3'(CTRL_PAD) : 3'd0;
            end
        end else if (deliver) begin
            if (pad_left != 3'd0) begin
                insn_nx = 20'h00000;
                pad_nx  = 1'b1;
                left_nx = pad_left - 3'd1;
            end else begin
                valid_nx = 1'b0;
                pad_nx   = 1'b0;
            end
        end

        // S_PAD covers both a pad on the output and a control word that
        // still owes pads.
        if (!valid_nx) begin
            state_nx = S_EMPTY;
        end else if (pad_nx || (left_nx != 3'd0)) begin
            state_nx = S_PAD;
        end else begin
            state_nx = S_INSN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_EMPTY;
            out_insn    <= 20'h00000;
            out_is_pad  <= 1'b0;
            pad_left    <= 3'd0;
            err_illegal <= 1'b0;
            insn_count  <= 16'h0000;
        end else begin
            state       <= state_nx;
            out_insn    <= insn_nx;
            out_is_pad  <= pad_nx;
            pad_left    <= left_nx;
            err_illegal <= err_nx;
            insn_count  <= count_nx;
        end
    end

endmodule

// File: tb/tb_lc4_insn_encoder.sv
// ---------------------------------------------------------------------------
// tb_lc4_insn_encoder
//   Self-checking bench for lc4_insn_encoder. A negedge monitor keeps a
//   queue of expected {is_pad, insn} words. Words are pushed when a request
//   is accepted and popped when the DUT delivers one. Directed sequences
//   check known encodings, pads, backpressure, illegal opcodes and reset.
//   Random traffic then runs with random out_ready.
// ---------------------------------------------------------------------------
module tb_lc4_insn_encoder;

    localparam int PAD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0, in_rd = '0, in_rs = '0, in_rt = '0;
    logic [14:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_insn;
    logic        out_is_pad;
    logic        err_illegal;
    logic [15:0] insn_count;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    logic [20:0] exp_q[$];
    logic        err_exp = 1'b0;
    logic [15:0] cnt_exp = '0;
    logic        rand_rdy = 1'b0;

    lc4_insn_encoder #(.CTRL_PAD(PAD)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_is_pad(out_is_pad),
        .err_illegal(err_illegal), .insn_count(insn_count), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference encoding, written from the format table.
    function automatic logic [19:0] ref_enc(input logic [4:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [14:0] imm);
        logic [19:0] w;
        w = {op, 15'h0000};
        if (op inside {5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd15, 5'd18, 5'd20, 5'd21})
            w = {op, rd, rs, rt};
        else if (op inside {5'd7, 5'd9, 5'd22})
            w = {op, rd, rs, imm[4:0]};
        else if (op inside {5'd16, 5'd19, 5'd25})
            w = {op, 5'd0, rs, 5'd0};
        else if (op inside {5'd11, 5'd23, 5'd24})
            w = {op, rd, imm[9:0]};
        else if (op <= 5'd4 || op == 5'd8)
            w = {op, imm};
        return w;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [20:0] e;
        if (rst) begin
            exp_q.delete();
            err_exp = 1'b0;
            cnt_exp = '0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            chk("in_ready", 32'(in_ready),
                32'(exp_q.size() == 0 || (exp_q.size() == 1 && out_ready)));
            chk("err_illegal", 32'(err_illegal), 32'(err_exp));
            chk("insn_count", 32'(insn_count), 32'(cnt_exp));
            if (exp_q.size() > 0)
                chk("word", 32'({out_is_pad, out_insn}), 32'(exp_q[0]));
            err_exp = 1'b0;
            if (exp_q.size() > 0 && out_ready) begin
                e = exp_q.pop_front();
                if (!e[20]) cnt_exp = cnt_exp + 16'd1;
            end
            if (in_valid && in_ready) begin
                if (in_op >= 5'd26) begin
                    err_exp = 1'b1;
                end else begin
                    exp_q.push_back({1'b0, ref_enc(in_op, in_rd, in_rs, in_rt, in_imm)});
                    if (in_op == 5'd8 || in_op == 5'd10)
                        for (int i = 0; i < PAD; i++) exp_q.push_back({1'b1, 20'h00000});
                end
            end
        end
    end

    // Random backpressure during the random phase.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [14:0] imm);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [4:0] op;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_insn", 32'(out_insn), 32'd0);
        chk("rst_is_pad", 32'(out_is_pad), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_count", 32'(insn_count), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD r3, r4, r5
        send(5'b00101, 5'd3, 5'd4, 5'd5, 15'h7FFF);
        @(negedge clk);
        chk("add_word", 32'(out_insn), 32'h28C85);
        chk("add_pad", 32'(out_is_pad), 32'd0);
        chk("add_state", 32'(state_dbg), 32'd1);
        @(negedge clk);
        chk("add_count", 32'(insn_count), 32'd1);
        @(posedge clk); #1;

        // ADDI r1, r2, imm truncated to 5 bits; rt ignored
        send(5'b00111, 5'd1, 5'd2, 5'd31, 15'h7FFF);
        @(negedge clk);
        chk("addi_word", 32'(out_insn), 32'h3845F);
        @(posedge clk); #1;

        // Rs-only: rd and rt ignored
        send(5'b10000, 5'd7, 5'd9, 5'd5, 15'h1234);
        @(negedge clk);
        chk("rsonly_word", 32'(out_insn), 32'h80120);
        @(posedge clk); #1;

        // I10: imm truncated to 10 bits
        send(5'b01011, 5'd2, 5'd9, 5'd9, 15'h7FFF);
        @(negedge clk);
        chk("i10_word", 32'(out_insn), 32'h58BFF);
        @(posedge clk); #1;

        // JSR followed by two pads
        send(5'b01000, 5'd1, 5'd1, 5'd1, 15'h0123);
        @(negedge clk);
        chk("jsr_word", 32'(out_insn), 32'h40123);
        chk("jsr_pad", 32'(out_is_pad), 32'd0);
        chk("jsr_state", 32'(state_dbg), 32'd2);
        chk("jsr_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("jsr_pad1_word", 32'(out_insn), 32'h00000);
        chk("jsr_pad1_flag", 32'(out_is_pad), 32'd1);
        chk("jsr_pad1_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("jsr_pad2_flag", 32'(out_is_pad), 32'd1);
        chk("jsr_pad2_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("jsr_done_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Illegal opcode
        send(5'b11100, 5'd1, 5'd2, 5'd3, 15'h0000);
        @(negedge clk);
        chk("ill_valid", 32'(out_valid), 32'd0);
        chk("ill_err", 32'(err_illegal), 32'd1);
        @(negedge clk);
        chk("ill_err_clear", 32'(err_illegal), 32'd0);
        @(posedge clk); #1;

        // Backpressure: A held for 5 cycles while B waits
        out_ready = 1'b0;
        send(5'b00101, 5'd3, 5'd4, 5'd5, 15'h0000);
        in_valid = 1'b1;
        in_op = 5'b01100; in_rd = 5'd1; in_rs = 5'd2; in_rt = 5'd3; in_imm = 15'h0000;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_word", 32'(out_insn), 32'h28C85);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_word", 32'(out_insn), 32'h60443);
        @(posedge clk); #1;

        // RTI, reset during its second pad; request during reset ignored
        send(5'b01010, 5'd3, 5'd3, 5'd3, 15'h7ABC);
        @(negedge clk);
        chk("rti_word", 32'(out_insn), 32'h50000);
        @(negedge clk);
        chk("rti_pad1", 32'(out_is_pad), 32'd1);
        @(negedge clk);
        chk("rti_pad2", 32'(out_is_pad), 32'd1);
        #1;
        rst = 1'b1;
        in_valid = 1'b1;
        in_op = 5'b00101; in_rd = 5'd1; in_rs = 5'd1; in_rt = 5'd1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_pad", 32'(out_is_pad), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_count", 32'(insn_count), 32'd0);
        @(posedge clk); #1;

        // Random traffic with random backpressure
        rand_rdy = 1'b1;
        for (int t = 0; t < 150; t++) begin
            do op = 5'($urandom_range(0, 31)); while (op == 5'd17);
            send(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 15'($urandom_range(0, 32767)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
